seg_display_scan: RTL and testbench
===================================

Name: seg_display_scan

Overview:
- Downstream consumer of the clock time-keeping counter.
- Takes the six BCD time digits (HH:MM:SS) and the 2-bit adjust mode, and drives a 6-digit multiplexed 7-segment display.
- Scans one digit at a time and blanks the field being adjusted at a blink rate.
- Sits between the time counter and the board segment/digit pins.

Parameters:
- SCAN_DIV, 50000: clk cycles each digit stays selected; must be ≥ 2.
- BLINK_DIV, 25000000: clk cycles per blink half-period; must be ≥ 2.
- ACTIVE_LOW, 0: 1 inverts all seg and dig_en outputs for common-anode boards.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- h_ten, h_one, m_ten, m_one, s_ten, s_one  in  4 each  BCD time digits
- adjust_mode  in  2  0 = run, 1 = seconds, 2 = minutes, 3 = hours selected
- seg  out  8  seg[0]=a … seg[6]=g, seg[7]=dp; 1 = lit when ACTIVE_LOW=0
- dig_en  out  6  one-hot digit select; bit0 = s_one … bit5 = h_ten

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk. All state is updated on posedge clk.
- Reset values:
  - scan_cnt = 0, idx = 0, blink_cnt = 0, blink_phase = 0, prev_mode = 0.
  - seg and dig_en are at their inactive level: 0 when ACTIVE_LOW=0, all-ones when ACTIVE_LOW=1.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - On the cycle it wraps, idx advances 0→1→…→5→0.
  - Each digit is therefore held for exactly SCAN_DIV cycles.
- Output registers:
  - seg and dig_en are registered from the current idx and current digit inputs.
  - Latency is 1 clk: an input change on the selected digit appears on seg at the next edge.
  - dig_en = 1 << idx, before polarity inversion.
  - The first clk edge after rst release drives dig_en = 000001.
- Decode (a..g into seg[6:0]):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F.
  - Any input value 10–15 shows a dash (40).
- Decimal points: seg[7] = 1 on idx 2 and idx 4 (separators after MM and HH); 0 elsewhere.
- Blink counter:
  - blink_cnt counts 0..BLINK_DIV-1 and toggles blink_phase on each wrap.
  - Full blink period is 2·BLINK_DIV cycles.
- Blanking:
  - Applies when adjust_mode ≠ 0 and blink_phase = 1, to the selected field only: mode 1 → idx 0,1; mode 2 → idx 2,3; mode 3 → idx 4,5.
  - A blanked digit drives seg[6:0] = 0; dp is unchanged.
  - dig_en keeps scanning unchanged, so brightness timing is constant.
- Mode change:
  - A mode change is adjust_mode ≠ prev_mode. prev_mode is registered every clk.
  - In that cycle, blink_cnt → 0 and blink_phase → 0, so the newly selected field is visible immediately.
  - The scan counter is not disturbed by a mode change.
- Mode 0: blink_cnt keeps running, but there is never any blanking.
- Reset mid-scan: outputs go inactive asynchronously. After release, scanning restarts at idx 0 with full-length dwell.
- Polarity: ACTIVE_LOW inverts seg and dig_en at the output register. Internal logic is unaffected.
- Counter widths: $clog2 of each divisor; no overflow beyond DIV-1.

Test Plan (SCAN_DIV=4, BLINK_DIV=16, ACTIVE_LOW=0 unless noted):
- Reset then release; time 12:34:56, mode 0 → dig_en steps 000001, 000010, … 100000, 000001, every 4 clks. seg sequence: 7D, 6D, E6 (4 with dp), 4F, DB (2 with dp), 06.
- During rst → seg = 00, dig_en = 000000 asynchronously. After release, the first edge gives dig_en = 000001.
- Mode 2, time 12:34:56:
  - Cycles 0–15 after the mode change: idx 2 → E6, idx 3 → 4F.
  - Cycles 16–31: idx 2 → 80 (dp only), idx 3 → 00.
  - Other digits are never blanked.
- Mode 2→3 at a cycle where blink_phase = 1 → hours visible at the next scan of idx 4/5, and blanking of hours begins 16 cycles after the change.
- h_one = 4'hC → a dash (40) whenever idx = 4. Change s_one 5→6 while idx = 0 → seg goes 6D→7D on the next clk.
- ACTIVE_LOW=1, time 00:00:00, mode 0 → dig_en = 111110 at idx 0, seg = C0. During reset, all outputs are ones.

Source files
------------

// File: rtl/seg_display_scan_if.sv
// seg_display_scan_if: time digits and adjust mode in, segment/digit drive out
interface seg_display_scan_if;
  logic [3:0] h_ten, h_one, m_ten, m_one, s_ten, s_one;
  logic [1:0] adjust_mode;
  logic [7:0] seg;
  logic [5:0] dig_en;
  modport master(output h_ten, h_one, m_ten, m_one, s_ten, s_one, adjust_mode, input seg, dig_en);
  modport slave(input h_ten, h_one, m_ten, m_one, s_ten, s_one, adjust_mode, output seg, dig_en);
endinterface

// File: rtl/seg_display_scan.sv
// seg_display_scan: multiplexed 6-digit 7-segment driver with blinking of the field being adjusted
module seg_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_DIV = 25000000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input logic clk,
  input logic rst,
  seg_display_scan_if.slave bus
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [SW-1:0] scan_cnt;
  logic [2:0] idx;
  logic [BW-1:0] blink_cnt;
  logic blink_phase;
  logic [1:0] prev_mode;
  logic scan_wrap, blink_wrap, mode_change, blank;
  logic [3:0] digit;
  logic [6:0] glyph;
  logic [7:0] seg_n;
  logic [5:0] dig_n;
  always_comb begin
    scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);
    blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
    mode_change = bus.adjust_mode != prev_mode;
    digit = idx == 3'd0 ? bus.s_one : idx == 3'd1 ? bus.s_ten : idx == 3'd2 ? bus.m_one :
            idx == 3'd3 ? bus.m_ten : idx == 3'd4 ? bus.h_one : bus.h_ten;
    glyph = 7'h40;
    case (digit)
      4'd0: glyph = 7'h3F;
      4'd1: glyph = 7'h06;
      4'd2: glyph = 7'h5B;
      4'd3: glyph = 7'h4F;
      4'd4: glyph = 7'h66;
      4'd5: glyph = 7'h6D;
      4'd6: glyph = 7'h7D;
      4'd7: glyph = 7'h07;
      4'd8: glyph = 7'h7F;
      4'd9: glyph = 7'h6F;
      default: glyph = 7'h40;
    endcase
    // a mode change restarts the blink visible, so the new field is never blanked in that cycle
    blank = blink_phase && !mode_change && bus.adjust_mode != 2'd0 && idx[2:1] == bus.adjust_mode - 2'd1;
    seg_n = {idx == 3'd2 || idx == 3'd4, blank ? 7'd0 : glyph};
    dig_n = 6'd1 << idx;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scan_cnt <= '0;
      idx <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b0;
      prev_mode <= 2'd0;
      bus.seg <= {8{ACTIVE_LOW}};
      bus.dig_en <= {6{ACTIVE_LOW}};
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      idx <= scan_wrap ? (idx == 3'd5 ? 3'd0 : idx + 3'd1) : idx;
      blink_cnt <= mode_change || blink_wrap ? '0 : blink_cnt + 1'b1;
      blink_phase <= mode_change ? 1'b0 : blink_phase ^ blink_wrap;
      prev_mode <= bus.adjust_mode;
      bus.seg <= seg_n ^ {8{ACTIVE_LOW}};
      bus.dig_en <= dig_n ^ {6{ACTIVE_LOW}};
    end
endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: random and directed stimulus against a cycle-count reference model, both polarities
module tb_seg_display_scan;
  localparam int SCAN = 4;
  localparam int BLINK = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] h_ten, h_one, m_ten, m_one, s_ten, s_one;
  logic [1:0] adj;
  int tests = 0;
  int fails = 0;
  int n = 0;
  int anchor = 0;
  int prev_m = 0;
  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  seg_display_scan_if bus_h();
  seg_display_scan_if bus_l();
  assign bus_h.h_ten = h_ten;
  assign bus_h.h_one = h_one;
  assign bus_h.m_ten = m_ten;
  assign bus_h.m_one = m_one;
  assign bus_h.s_ten = s_ten;
  assign bus_h.s_one = s_one;
  assign bus_h.adjust_mode = adj;
  assign bus_l.h_ten = h_ten;
  assign bus_l.h_one = h_one;
  assign bus_l.m_ten = m_ten;
  assign bus_l.m_one = m_one;
  assign bus_l.s_ten = s_ten;
  assign bus_l.s_one = s_one;
  assign bus_l.adjust_mode = adj;
  seg_display_scan #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .ACTIVE_LOW(1'b0)) dut_h (.clk(clk), .rst(rst), .bus(bus_h));
  seg_display_scan #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK), .ACTIVE_LOW(1'b1)) dut_l (.clk(clk), .rst(rst), .bus(bus_l));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask
  task automatic chk_inactive();
    chk("rst_seg", bus_h.seg, 8'h00);
    chk("rst_dig", {2'b0, bus_h.dig_en}, 8'h00);
    chk("rst_seg_l", bus_l.seg, 8'hFF);
    chk("rst_dig_l", {2'b0, bus_l.dig_en}, 8'h3F);
  endtask
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk_inactive();
    @(posedge clk);
    #1 chk_inactive();
    #2 rst = 1'b0;
    n = 0;
    anchor = 0;
    prev_m = 0;
  endtask
  task automatic set_time(int hh, int mm, int ss);
    h_ten = 4'(hh / 10); h_one = 4'(hh % 10);
    m_ten = 4'(mm / 10); m_one = 4'(mm % 10);
    s_ten = 4'(ss / 10); s_one = 4'(ss % 10);
  endtask
  // Expected output at edge n: digit index from elapsed dwell, blink phase from edges since the last restart.
  task automatic step(int cnt);
    for (int c = 0; c < cnt; c++) begin
      logic [3:0] digs [6];
      logic [7:0] es;
      logic [5:0] ed;
      int i, ph;
      bit mc, blank;
      @(posedge clk);
      #1;
      n++;
      mc = int'(adj) != prev_m;
      i = ((n - 1) / SCAN) % 6;
      ph = ((n - 1 - anchor) / BLINK) % 2;
      blank = adj != 2'd0 && ph == 1 && !mc && i / 2 == int'(adj) - 1;
      digs = '{s_one, s_ten, m_one, m_ten, h_one, h_ten};
      es = {i == 2 || i == 4, blank ? 7'd0 : dec_tab[digs[i]]};
      ed = 6'(1 << i);
      chk("seg", bus_h.seg, es);
      chk("dig_en", {2'b0, bus_h.dig_en}, {2'b0, ed});
      chk("seg_l", bus_l.seg, ~es);
      chk("dig_en_l", {2'b0, bus_l.dig_en}, {2'b0, ~ed});
      if (mc) anchor = n;
      prev_m = int'(adj);
    end
  endtask
  initial begin
    set_time(12, 34, 56);
    adj = 2'd0;
    do_reset();
    step(30);
    adj = 2'd2;
    step(20);
    adj = 2'd3;
    step(50);
    h_one = 4'hC;
    step(30);
    adj = 2'd0;
    step(6);
    s_one = 4'd6;
    step(3);
    s_one = 4'd5;
    step(10);
    set_time(0, 0, 0);
    do_reset();
    step(30);
    for (int r = 0; r < 800; r++) begin
      if ($urandom_range(7) == 0) begin
        case ($urandom_range(5))
          0: h_ten = 4'($urandom);
          1: h_one = 4'($urandom);
          2: m_ten = 4'($urandom);
          3: m_one = 4'($urandom);
          4: s_ten = 4'($urandom);
          default: s_one = 4'($urandom);
        endcase
      end
      if ($urandom_range(39) == 0) adj = 2'($urandom);
      if (r == 400) begin
        adj = 2'd1;
        do_reset();
      end
      step(1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
